nios_system_nios2_cpu_oci_dct_ctrl: RTL and testbench

Sequencer for the OCI direct-control-transfer (DCT) trace buffer. Packs 2-bit DCT codes from the CPU trace logic into a 30-bit shift buffer with a 4-bit entry count. Hands full or flushed buffers to the trace FIFO as 36-bit frames over a valid/ready handshake. Counts codes lost to backpressure.

---
 rtl/nios_system_nios2_cpu_oci_dct_ctrl.sv | 97 +++++++++
 tb/tb_nios_system_nios2_cpu_oci_dct_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_system_nios2_cpu_oci_dct_ctrl.sv
// OCI DCT trace-buffer sequencer.
// Packs 2-bit DCT codes into a 30-bit shift buffer and hands full or flushed
// buffers to the trace FIFO as 36-bit frames {ovf, flushed, count, buffer}.
// Optional feature macro: DCT_OVF_COUNT_EN builds the 16-bit saturating
// dropped-code counter; without it ovf_cnt reads as zero.
module nios_system_nios2_cpu_oci_dct_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        trc_en,
    input  logic        dct_valid,
    input  logic [1:0]  dct_code,
    input  logic        dct_flush,
    output logic        frm_valid,
    input  logic        frm_ready,
    output logic [35:0] frm_data,
    output logic [3:0]  dct_count,
    output logic [29:0] dct_buffer,
    output logic [15:0] ovf_cnt
);

    logic flush_pend;
    logic ovf_pend;

    logic out_free;
    logic is_full;
    logic is_empty;
    logic xfer;
    logic code_in;
    logic drop;
    logic accept;
    logic empty_next;

    // Transfer / accept / drop decisions for this cycle.
    always_comb begin
        out_free   = !frm_valid || frm_ready;
        is_full    = (dct_count == 4'd15);
        is_empty   = (dct_count == 4'd0);
        xfer       = out_free && (is_full || (flush_pend && !is_empty));
        code_in    = dct_valid && trc_en;
        drop       = code_in && is_full && !xfer;
        accept     = code_in && !drop;
        // Buffer will hold nothing after this edge: a pending flush has nothing to emit.
        empty_next = (xfer || is_empty) && !accept;
    end

    // Shift buffer, entry count and pending flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dct_buffer <= '0;
            dct_count  <= '0;
            ovf_pend   <= 1'b0;
            flush_pend <= 1'b0;
        end else begin
            if (xfer) begin
                // A code arriving on the transfer edge starts the freshly cleared buffer.
                dct_buffer <= accept ? {28'b0, dct_code} : '0;
                dct_count  <= accept ? 4'd1 : 4'd0;
            end else if (accept) begin
                dct_buffer <= {dct_buffer[27:0], dct_code};
                dct_count  <= dct_count + 4'd1;
            end

            if (xfer)
                ovf_pend <= 1'b0;
            else if (drop)
                ovf_pend <= 1'b1;

            flush_pend <= (dct_flush || (flush_pend && !xfer)) && !empty_next;
        end
    end

    // Single-entry output register with valid/ready handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frm_valid <= 1'b0;
            frm_data  <= '0;
        end else if (xfer) begin
            frm_valid <= 1'b1;
            frm_data  <= {ovf_pend, !is_full, dct_count, dct_buffer};
        end else if (frm_ready) begin
            frm_valid <= 1'b0;
        end
    end

`ifdef DCT_OVF_COUNT_EN
    // Saturating count of codes lost to backpressure.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            ovf_cnt <= '0;
        else if (drop && (ovf_cnt != 16'hFFFF))
            ovf_cnt <= ovf_cnt + 16'd1;
    end
`else
    assign ovf_cnt = '0;
`endif

endmodule

// File: tb/tb_nios_system_nios2_cpu_oci_dct_ctrl.sv
// Self-checking bench for the OCI DCT trace-buffer sequencer.
module tb_nios_system_nios2_cpu_oci_dct_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        trc_en;
    logic        dct_valid;
    logic [1:0]  dct_code;
    logic        dct_flush;
    logic        frm_valid;
    logic        frm_ready;
    logic [35:0] frm_data;
    logic [3:0]  dct_count;
    logic [29:0] dct_buffer;
    logic [15:0] ovf_cnt;

    int checks = 0;
    int errors = 0;

    nios_system_nios2_cpu_oci_dct_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .trc_en     (trc_en),
        .dct_valid  (dct_valid),
        .dct_code   (dct_code),
        .dct_flush  (dct_flush),
        .frm_valid  (frm_valid),
        .frm_ready  (frm_ready),
        .frm_data   (frm_data),
        .dct_count  (dct_count),
        .dct_buffer (dct_buffer),
        .ovf_cnt    (ovf_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: the buffer is a list of codes, oldest first.
    int          m_q[$];
    bit          m_flush;
    bit          m_ovf;
    bit          m_fv;
    logic [35:0] m_fd;
    int          m_drops;

    function automatic logic [29:0] pack_codes();
        logic [29:0] v = '0;
        foreach (m_q[i]) v = (v << 2) | 30'(m_q[i]);
        return v;
    endfunction

    function automatic logic [15:0] exp_ovf_cnt();
`ifdef DCT_OVF_COUNT_EN
        return (m_drops > 65535) ? 16'hFFFF : 16'(m_drops);
`else
        return 16'h0000;
`endif
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_flush = 0;
        m_ovf   = 0;
        m_fv    = 0;
        m_fd    = '0;
        m_drops = 0;
    endtask

    task automatic model_step(input bit v, input int c, input bit f, input bit r, input bit t);
        int  n       = m_q.size();
        bit  can_out = !m_fv || r;
        bit  emit    = can_out && (n == 15 || (m_flush && n > 0));
        bit  arrive  = v && t;
        bit  lost    = arrive && n == 15 && !emit;
        if (emit) begin
            m_fd = {m_ovf, (n < 15) ? 1'b1 : 1'b0, 4'(n), pack_codes()};
            m_fv = 1;
            m_q.delete();
            m_ovf = 0;
        end else if (r) begin
            m_fv = 0;
        end
        if (arrive && !lost) m_q.push_back(c);
        if (lost) begin
            m_ovf = 1;
            m_drops++;
        end
        m_flush = (f || (m_flush && !emit)) && (m_q.size() != 0);
    endtask

    task automatic check(input string name, input logic [35:0] got, input logic [35:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic check_model();
        check("count",   36'(dct_count),  36'(m_q.size()));
        check("buffer",  36'(dct_buffer), 36'(pack_codes()));
        check("valid",   36'(frm_valid),  36'(m_fv));
        check("data",    frm_data,        m_fd);
        check("ovf_cnt", 36'(ovf_cnt),    36'(exp_ovf_cnt()));
    endtask

    task automatic tick(input bit v, input int c, input bit f, input bit r, input bit t);
        dct_valid = v;
        dct_code  = 2'(c);
        dct_flush = f;
        frm_ready = r;
        trc_en    = t;
        model_step(v, c, f, r, t);
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        dct_valid = 0;
        dct_code  = 0;
        dct_flush = 0;
        frm_ready = 0;
        trc_en    = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    typedef struct {
        bit          v;
        int          c;
        bit          f;
        bit          r;
        bit          t;
        logic [3:0]  cnt;
        logic [29:0] buff;
        bit          fv;
        logic [35:0] fd;
    } vec_t;

    vec_t        tbl[8];
    logic [35:0] frame1;
    logic [35:0] flush_frm;

    initial begin
        flush_frm = {1'b0, 1'b1, 4'h3, 30'h00000039};
        tbl[0] = '{1, 3, 0, 1, 1, 4'd1, 30'h3,  0, 36'h0};
        tbl[1] = '{1, 2, 0, 1, 1, 4'd2, 30'hE,  0, 36'h0};
        tbl[2] = '{1, 1, 0, 1, 1, 4'd3, 30'h39, 0, 36'h0};
        tbl[3] = '{0, 0, 1, 1, 1, 4'd3, 30'h39, 0, 36'h0};
        tbl[4] = '{0, 0, 0, 1, 1, 4'd0, 30'h0,  1, flush_frm};
        tbl[5] = '{0, 0, 0, 1, 1, 4'd0, 30'h0,  0, flush_frm};
        tbl[6] = '{0, 0, 1, 1, 1, 4'd0, 30'h0,  0, flush_frm};
        tbl[7] = '{0, 0, 0, 1, 1, 4'd0, 30'h0,  0, flush_frm};

        // Reset state.
        do_reset();
        #1;
        check("rst_valid",  36'(frm_valid),  36'h0);
        check("rst_data",   frm_data,        36'h0);
        check("rst_count",  36'(dct_count),  36'h0);
        check("rst_buffer", 36'(dct_buffer), 36'h0);
        check("rst_ovf",    36'(ovf_cnt),    36'h0);

        // Table: partial buffer flushed, then a flush with an empty buffer.
        for (int i = 0; i < 8; i++) begin
            tick(tbl[i].v, tbl[i].c, tbl[i].f, tbl[i].r, tbl[i].t);
            check($sformatf("tbl%0d_count", i),  36'(dct_count),  36'(tbl[i].cnt));
            check($sformatf("tbl%0d_buffer", i), 36'(dct_buffer), 36'(tbl[i].buff));
            check($sformatf("tbl%0d_valid", i),  36'(frm_valid),  36'(tbl[i].fv));
            check($sformatf("tbl%0d_data", i),   frm_data,        tbl[i].fd);
        end

        // Fifteen codes 01 with ready high -> one full frame.
        do_reset();
        for (int i = 0; i < 15; i++) tick(1, 1, 0, 1, 1);
        check("full_count",  36'(dct_count),  36'hF);
        check("full_buffer", 36'(dct_buffer), 36'h15555555);
        tick(0, 0, 0, 1, 1);
        check("full_valid", 36'(frm_valid), 36'h1);
        check("full_data",  frm_data, {1'b0, 1'b0, 4'hF, 30'h15555555});
        check("full_cnt0",  36'(dct_count), 36'h0);

        // Code on the transfer edge lands in the cleared buffer.
        do_reset();
        for (int i = 0; i < 15; i++) tick(1, 3, 0, 1, 1);
        tick(1, 2, 0, 1, 1);
        check("same_edge_valid",  36'(frm_valid),  36'h1);
        check("same_edge_count",  36'(dct_count),  36'h1);
        check("same_edge_buffer", 36'(dct_buffer), 36'h2);
        check("same_edge_data",   frm_data, {1'b0, 1'b0, 4'hF, 30'h3FFFFFFF});

        // Backpressure: 31 codes with ready low, last one dropped.
        do_reset();
        frame1 = '0;
        for (int i = 0; i < 31; i++) begin
            tick(1, i % 4, 0, 0, 1);
            if (i == 15) frame1 = frm_data;
        end
        check("bp_held",    frm_data, frame1);
        check("bp_valid",   36'(frm_valid), 36'h1);
        check("bp_count",   36'(dct_count), 36'hF);
`ifdef DCT_OVF_COUNT_EN
        check("bp_ovf_cnt", 36'(ovf_cnt), 36'h1);
`else
        check("bp_ovf_cnt", 36'(ovf_cnt), 36'h0);
`endif
        tick(0, 0, 0, 1, 1);
        check("bp_ovf_bit",  36'(frm_data[35]), 36'h1);
        check("bp_flushbit", 36'(frm_data[34]), 36'h0);

        // Asynchronous reset mid-fill with a frame held.
        do_reset();
        for (int i = 0; i < 16; i++) tick(1, 2, 0, 0, 1);
        for (int i = 0; i < 6; i++) tick(1, 1, 0, 0, 1);
        check("pre_rst_valid", 36'(frm_valid), 36'h1);
        check("pre_rst_count", 36'(dct_count), 36'h7);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_valid",  36'(frm_valid),  36'h0);
        check("async_data",   frm_data,        36'h0);
        check("async_count",  36'(dct_count),  36'h0);
        check("async_buffer", 36'(dct_buffer), 36'h0);
        check("async_ovf",    36'(ovf_cnt),    36'h0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            tick(($urandom_range(0, 9) < 7), int'($urandom_range(0, 3)),
                 ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 9) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
